// File: rtl/writeback_arbiter_pkg.sv
// Shared types and register-index constants for the writeback arbiter slice.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
//
// The macro block below is the shared register-index header: `R_ZERO, `SP and
// the default slow-path FIFO depth `WB_FIFO_DEPTH. It is guarded so that
// re-inclusion elsewhere is harmless.
`ifndef WB_MACRO_DEFINES
`define WB_MACRO_DEFINES
`define R_ZERO        4'd0
`define SP            4'd14
`define WB_FIFO_DEPTH 2
`endif

package writeback_arbiter_pkg;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 1 << REG_W;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    // One buffered slow-path result: destination register plus value.
    typedef struct packed {
        reg_idx_t rd;
        data_t    data;
    } wb_entry_t;

    function automatic logic is_zero_reg(input reg_idx_t r);
        return r == `R_ZERO;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Bundles every writeback-stage signal: ALU stream, slow stream, issue/check, regfile port, bypass.
// Latency: n/a (wires only).
// Backpressure: ld_ready on the slow stream; the ALU stream only sees alu_stall (one cycle ahead).
//
// Modports: slave  = arbiter side (consumes results, drives the register file)
//           master = producer/regfile side (offers results, reads hazard/bypass)
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic     alu_valid;
    reg_idx_t alu_reg;
    data_t    alu_data;
    logic     alu_stall;

    logic     ld_valid;
    logic     ld_ready;
    reg_idx_t ld_reg;
    data_t    ld_data;

    logic     iss_valid;
    reg_idx_t iss_reg;
    reg_idx_t chk_reg1;
    reg_idx_t chk_reg2;
    logic     hazard;

    logic     reg_write;
    reg_idx_t write_reg;
    data_t    write_data;

    reg_idx_t read_reg1;
    reg_idx_t read_reg2;
    data_t    read_data1;
    data_t    read_data2;
    data_t    byp_data1;
    data_t    byp_data2;

    modport slave (
        input  alu_valid, alu_reg, alu_data,
        output alu_stall,
        input  ld_valid, ld_reg, ld_data,
        output ld_ready,
        input  iss_valid, iss_reg, chk_reg1, chk_reg2,
        output hazard,
        output reg_write, write_reg, write_data,
        input  read_reg1, read_reg2, read_data1, read_data2,
        output byp_data1, byp_data2
    );

    modport master (
        output alu_valid, alu_reg, alu_data,
        input  alu_stall,
        output ld_valid, ld_reg, ld_data,
        input  ld_ready,
        output iss_valid, iss_reg, chk_reg1, chk_reg2,
        input  hazard,
        input  reg_write, write_reg, write_data,
        output read_reg1, read_reg2, read_data1, read_data2,
        input  byp_data1, byp_data2
    );

endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Small synchronous FIFO for buffered slow-path {reg,data} results.
// Latency: pushed entry visible at pop_dat the cycle after the push (no cut-through).
// Backpressure: full asserted at DEPTH entries; push while full and pop while empty are ignored.
//
// Ports: clk, reset (sync, active-high), push/push_dat, pop/pop_dat, full, empty.
// DEPTH must be a power of two >= 2 so the pointers wrap by plain overflow.
module wb_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Sole driver of the regfile write port: merges the ALU stream with the buffered slow stream,
// Latency: winner in cycle N appears on reg_write/write_reg/write_data in N+1 (slow path adds one FIFO cycle).
// Backpressure: ld_ready = !full (0 in reset); alu_stall pulses after STARVE_MAX starved cycles.
//
// Ports: clk, reset (sync, active-high), wb (writeback_arbiter_if.slave).
// Build option: WB_BYPASS_EN forwards the registered write into byp_data1/2 when it
// matches the read address; without it byp_dataX is just read_dataX.
// A pending-write scoreboard drives hazard for decode RAW stalls.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = `WB_FIFO_DEPTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    writeback_arbiter_if.slave  wb
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_entry_t             push_dat;
    wb_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  alu_win;
    logic                  slow_win;

    logic [SW-1:0]         starve_cnt;
    logic [SW-1:0]         starve_nxt;
    logic                  alu_stall_q;

    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;

    logic                  reg_write_q;
    reg_idx_t              write_reg_q;
    data_t                 write_data_q;
    logic                  slow_wb_q;

    assign wb.ld_ready = !reset && !fifo_full;
    assign push        = wb.ld_valid && wb.ld_ready;
    assign push_dat    = '{rd: wb.ld_reg, data: wb.ld_data};

    // ALU results cannot be held off, so they always win; the FIFO head
    // drains on any cycle the ALU is idle.
    assign alu_win  = wb.alu_valid;
    assign slow_win = !wb.alu_valid && !fifo_empty;

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (slow_win),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Starvation counter saturates at STARVE_MAX so a misbehaving upstream
    // that ignores alu_stall keeps re-triggering the stall pulse.
    always_comb begin
        starve_nxt = starve_cnt;
        if (slow_win) begin
            starve_nxt = '0;
        end else if (alu_win && !fifo_empty && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + 1'b1;
        end
    end

    // Clear on a committed slow write first, then set, so a same-register
    // issue in the commit cycle leaves the bit pending.
    always_comb begin
        pending_nxt = pending;
        if (reg_write_q && slow_wb_q) begin
            pending_nxt[write_reg_q] = 1'b0;
        end
        if (wb.iss_valid && !is_zero_reg(wb.iss_reg)) begin
            pending_nxt[wb.iss_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            slow_wb_q    <= 1'b0;
            alu_stall_q  <= 1'b0;
            starve_cnt   <= '0;
            pending      <= '0;
        end else begin
            starve_cnt  <= starve_nxt;
            // One-cycle pulse: high the cycle the count reaches the limit.
            alu_stall_q <= (starve_nxt == SW'(STARVE_MAX)) && !alu_stall_q;
            pending     <= pending_nxt;
            slow_wb_q   <= slow_win;
            if (alu_win) begin
                reg_write_q  <= !is_zero_reg(wb.alu_reg);
                write_reg_q  <= wb.alu_reg;
                write_data_q <= wb.alu_data;
            end else if (slow_win) begin
                // r0 entries still pop; the write enable is simply dropped.
                reg_write_q  <= !is_zero_reg(head.rd);
                write_reg_q  <= head.rd;
                write_data_q <= head.data;
            end else begin
                reg_write_q  <= 1'b0;
            end
        end
    end

    assign wb.reg_write  = reg_write_q;
    assign wb.write_reg  = write_reg_q;
    assign wb.write_data = write_data_q;
    assign wb.alu_stall  = alu_stall_q;

    assign wb.hazard = (!is_zero_reg(wb.chk_reg1) && pending[wb.chk_reg1]) ||
                       (!is_zero_reg(wb.chk_reg2) && pending[wb.chk_reg2]);

`ifdef WB_BYPASS_EN
    assign wb.byp_data1 = (reg_write_q && (write_reg_q == wb.read_reg1) && !is_zero_reg(write_reg_q))
                          ? write_data_q : wb.read_data1;
    assign wb.byp_data2 = (reg_write_q && (write_reg_q == wb.read_reg2) && !is_zero_reg(write_reg_q))
                          ? write_data_q : wb.read_data2;
`else
    assign wb.byp_data1 = wb.read_data1;
    assign wb.byp_data2 = wb.read_data2;
    logic unused_read_regs;
    assign unused_read_regs = &{1'b0, wb.read_reg1, wb.read_reg2};
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed, table-driven bench for writeback_arbiter (FIFO_DEPTH=2, STARVE_MAX=4).
// Latency: each table row is one clock; combinational outputs checked mid-cycle, registered ones after the edge.
// Backpressure: ld_ready and alu_stall expectations are part of each row.
module tb_writeback_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    writeback_arbiter_if wbif ();

    writeback_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wbif)
    );

`ifdef WB_BYPASS_EN
    localparam logic [15:0] BYP_EXP = 16'h00AA;
`else
    localparam logic [15:0] BYP_EXP = 16'h0000;
`endif

    typedef struct {
        logic        alu_v;
        logic [3:0]  alu_r;
        logic [15:0] alu_d;
        logic        ld_v;
        logic [3:0]  ld_r;
        logic [15:0] ld_d;
        logic        iss_v;
        logic [3:0]  iss_r;
        logic [3:0]  c1;
        logic [3:0]  c2;
        logic        e_haz;
        logic        e_rdy;
        logic        e_rw;
        logic [3:0]  e_wr;
        logic [15:0] e_wd;
        logic        e_stall;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    function automatic vec_t mk(int av, int ar, int ad, int lv, int lr, int ld,
                                int iv, int ir, int c1, int c2,
                                int eh, int erdy, int erw, int ewr, int ewd, int est);
        vec_t v;
        v.alu_v = 1'(av);  v.alu_r = 4'(ar);  v.alu_d = 16'(ad);
        v.ld_v  = 1'(lv);  v.ld_r  = 4'(lr);  v.ld_d  = 16'(ld);
        v.iss_v = 1'(iv);  v.iss_r = 4'(ir);
        v.c1    = 4'(c1);  v.c2    = 4'(c2);
        v.e_haz = 1'(eh);  v.e_rdy = 1'(erdy);
        v.e_rw  = 1'(erw); v.e_wr  = 4'(ewr); v.e_wd = 16'(ewd);
        v.e_stall = 1'(est);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        wbif.alu_valid = 1'b0; wbif.alu_reg = '0; wbif.alu_data = '0;
        wbif.ld_valid  = 1'b0; wbif.ld_reg  = '0; wbif.ld_data  = '0;
        wbif.iss_valid = 1'b0; wbif.iss_reg = '0;
        wbif.chk_reg1  = '0;   wbif.chk_reg2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // alu_stall high in one cycle forbids alu_valid in the following cycle.
    logic stall_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset && stall_prev) begin
            n_checks++;
            if (wbif.alu_valid) begin
                n_fail++;
                $display("FAIL alu_valid_after_stall: got alu_valid=1 expected 0");
            end
        end
        stall_prev <= wbif.alu_stall;
    end

    initial begin
        //                av ar ad       lv lr ld       iv ir c1 c2   haz rdy rw wr wd       stall
        vecs[0]  = mk(1, 3, 'h1234, 0, 0, 0,      0, 0, 0, 0,   0, 1, 1, 3, 'h1234, 0); // ALU only
        vecs[1]  = mk(0, 0, 0,      1, 5, 'hBEEF, 0, 0, 0, 0,   0, 1, 0, 0, 0,      0); // slow push
        vecs[2]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0,   0, 1, 1, 5, 'hBEEF, 0); // slow write N+2
        vecs[3]  = mk(1, 1, 'h0001, 1, 6, 'h0006, 0, 0, 0, 0,   0, 1, 1, 1, 'h0001, 0);
        vecs[4]  = mk(1, 2, 'h0002, 1, 8, 'h0008, 0, 0, 0, 0,   0, 1, 1, 2, 'h0002, 0); // starve 1, full
        vecs[5]  = mk(1, 3, 'h0003, 1, 9, 'h0009, 0, 0, 0, 0,   0, 0, 1, 3, 'h0003, 0); // full: rdy 0
        vecs[6]  = mk(1, 4, 'h0004, 0, 0, 0,      0, 0, 0, 0,   0, 0, 1, 4, 'h0004, 0);
        vecs[7]  = mk(1, 5, 'h0005, 0, 0, 0,      0, 0, 0, 0,   0, 0, 1, 5, 'h0005, 1); // 4th win -> stall
        vecs[8]  = mk(1, 10,'h000A, 0, 0, 0,      0, 0, 0, 0,   0, 0, 1, 10,'h000A, 0);
        vecs[9]  = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0,   0, 0, 1, 6, 'h0006, 0); // forced pop
        vecs[10] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0,   0, 1, 1, 8, 'h0008, 0);
        vecs[11] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0,   0, 1, 0, 0, 0,      0);
        vecs[12] = mk(0, 0, 0,      0, 0, 0,      1, 7, 7, 0,   0, 1, 0, 0, 0,      0); // issue r7
        vecs[13] = mk(0, 0, 0,      1, 7, 'h0777, 0, 0, 7, 0,   1, 1, 0, 0, 0,      0);
        vecs[14] = mk(0, 0, 0,      0, 0, 0,      0, 0, 7, 0,   1, 1, 1, 7, 'h0777, 0);
        vecs[15] = mk(0, 0, 0,      0, 0, 0,      0, 0, 7, 0,   1, 1, 0, 0, 0,      0); // clear at edge
        vecs[16] = mk(0, 0, 0,      0, 0, 0,      0, 0, 7, 3,   0, 1, 0, 0, 0,      0);
        vecs[17] = mk(0, 0, 0,      1, 7, 'h0700, 1, 7, 0, 7,   0, 1, 0, 0, 0,      0);
        vecs[18] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 7,   1, 1, 1, 7, 'h0700, 0);
        vecs[19] = mk(0, 0, 0,      0, 0, 0,      1, 7, 0, 7,   1, 1, 0, 0, 0,      0); // set+clear
        vecs[20] = mk(0, 0, 0,      0, 0, 0,      0, 0, 3, 7,   1, 1, 0, 0, 0,      0); // set wins
        vecs[21] = mk(0, 0, 0,      1, 7, 'h0701, 0, 0, 0, 7,   1, 1, 0, 0, 0,      0);
        vecs[22] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 7,   1, 1, 1, 7, 'h0701, 0);
        vecs[23] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 7,   1, 1, 0, 0, 0,      0);
        vecs[24] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 7,   0, 1, 0, 0, 0,      0);
        vecs[25] = mk(1, 0, 'hFFFF, 0, 0, 0,      0, 0, 0, 0,   0, 1, 0, 0, 0,      0); // ALU r0 dropped
        vecs[26] = mk(0, 0, 0,      1, 0, 'h1111, 1, 0, 0, 0,   0, 1, 0, 0, 0,      0); // slow r0, iss r0
        vecs[27] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0,   0, 1, 0, 0, 0,      0); // r0 pops silently
        vecs[28] = mk(0, 0, 0,      1, 4, 'h0044, 0, 0, 0, 0,   0, 1, 0, 0, 0,      0);
        vecs[29] = mk(0, 0, 0,      0, 0, 0,      0, 0, 0, 0,   0, 1, 1, 4, 'h0044, 0); // r0 entry gone

        drive_idle();
        wbif.read_reg1 = '0; wbif.read_reg2 = '0;
        wbif.read_data1 = '0; wbif.read_data2 = '0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_reg_write",  32'(wbif.reg_write),  32'd0);
        check("rst_write_reg",  32'(wbif.write_reg),  32'd0);
        check("rst_write_data", 32'(wbif.write_data), 32'd0);
        check("rst_alu_stall",  32'(wbif.alu_stall),  32'd0);
        check("rst_ld_ready",   32'(wbif.ld_ready),   32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ld_ready", 32'(wbif.ld_ready), 32'd1);
        check("post_rst_hazard",   32'(wbif.hazard),   32'd0);

        for (int i = 0; i < NV; i++) begin
            wbif.alu_valid = vecs[i].alu_v; wbif.alu_reg = vecs[i].alu_r; wbif.alu_data = vecs[i].alu_d;
            wbif.ld_valid  = vecs[i].ld_v;  wbif.ld_reg  = vecs[i].ld_r;  wbif.ld_data  = vecs[i].ld_d;
            wbif.iss_valid = vecs[i].iss_v; wbif.iss_reg = vecs[i].iss_r;
            wbif.chk_reg1  = vecs[i].c1;    wbif.chk_reg2 = vecs[i].c2;
            #1;
            check($sformatf("v%0d_hazard", i),   32'(wbif.hazard),   32'(vecs[i].e_haz));
            check($sformatf("v%0d_ld_ready", i), 32'(wbif.ld_ready), 32'(vecs[i].e_rdy));
            tick();
            check($sformatf("v%0d_reg_write", i), 32'(wbif.reg_write), 32'(vecs[i].e_rw));
            if (vecs[i].e_rw) begin
                check($sformatf("v%0d_write_reg", i),  32'(wbif.write_reg),  32'(vecs[i].e_wr));
                check($sformatf("v%0d_write_data", i), 32'(wbif.write_data), 32'(vecs[i].e_wd));
            end
            check($sformatf("v%0d_alu_stall", i), 32'(wbif.alu_stall), 32'(vecs[i].e_stall));
        end

        // Bypass: registered write of r4 seen by the read port in the same cycle.
        drive_idle();
        wbif.alu_valid = 1'b1; wbif.alu_reg = 4'd4; wbif.alu_data = 16'h00AA;
        wbif.read_reg1 = 4'd4; wbif.read_data1 = 16'h0000;
        wbif.read_reg2 = 4'd9; wbif.read_data2 = 16'h5555;
        tick();
        drive_idle();
        #1;
        check("byp_reg_write", 32'(wbif.reg_write), 32'd1);
        check("byp_data1_hit", 32'(wbif.byp_data1), 32'(BYP_EXP));
        check("byp_data2_miss", 32'(wbif.byp_data2), 32'h5555);
        tick();
        check("byp_data1_nowrite", 32'(wbif.byp_data1), 32'h0000);

        // Reset mid-operation: buffered entries and pending bits are discarded.
        wbif.alu_valid = 1'b1; wbif.alu_reg = 4'd1; wbif.alu_data = 16'h0101;
        wbif.ld_valid = 1'b1; wbif.ld_reg = 4'd11; wbif.ld_data = 16'h0B0B;
        wbif.iss_valid = 1'b1; wbif.iss_reg = 4'd13;
        tick();
        wbif.ld_reg = 4'd12; wbif.ld_data = 16'h0C0C;
        wbif.iss_valid = 1'b0;
        tick();
        drive_idle();
        wbif.chk_reg1 = 4'd13;
        #1;
        check("mid_pending_before_rst", 32'(wbif.hazard), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ld_ready", 32'(wbif.ld_ready), 32'd0);
        tick();
        check("mid_rst_reg_write", 32'(wbif.reg_write), 32'd0);
        check("mid_rst_alu_stall", 32'(wbif.alu_stall), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_hazard", 32'(wbif.hazard), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid_rst_drain%0d", k), 32'(wbif.reg_write), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
